// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one combinational bitwise logic unit between two
// requesters; operands are driven from registers and the opcode-selected result is returned.
module logic_op_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pi_req0,
  input  logic [2:0]        pi_op0,
  input  logic [DATA_W-1:0] pi_a0,
  input  logic [DATA_W-1:0] pi_b0,
  input  logic              pi_req1,
  input  logic [2:0]        pi_op1,
  input  logic [DATA_W-1:0] pi_a1,
  input  logic [DATA_W-1:0] pi_b1,
  input  logic [DATA_W-1:0] pi_lu_c,
  input  logic [DATA_W-1:0] pi_lu_d,
  input  logic [DATA_W-1:0] pi_lu_e,
  input  logic [DATA_W-1:0] pi_lu_f,
  input  logic [DATA_W-1:0] pi_lu_g,
  input  logic [DATA_W-1:0] pi_lu_h,
  input  logic [DATA_W-1:0] pi_lu_i,
  output logic [DATA_W-1:0] po_lu_a,
  output logic [DATA_W-1:0] po_lu_b,
  output logic              po_gnt0,
  output logic              po_gnt1,
  output logic              po_done0,
  output logic              po_done1,
  output logic [DATA_W-1:0] po_res,
  output logic              po_err,
  output logic              po_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              rr_r, rr_s;     // requester preferred on contention
  logic              id_r, id_s;
  logic [2:0]        op_r, op_s;
  logic [DATA_W-1:0] lu_a_s, lu_b_s, res_s;
  logic              gnt0_s, gnt1_s, done0_s, done1_s, err_s, busy_s;
  logic              grant_s, pick_s;
  logic [DATA_W:0]   sel_s;

  // Returns {err, result} for an opcode; opcode 7 is illegal and yields zero.
  function automatic logic [DATA_W:0] select_result(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] c, d, e, f, g, h, i
  );
    logic [DATA_W:0] r;
    case (op)
      3'd0:    r = {1'b0, c};
      3'd1:    r = {1'b0, d};
      3'd2:    r = {1'b0, e};
      3'd3:    r = {1'b0, f};
      3'd4:    r = {1'b0, g};
      3'd5:    r = {1'b0, h};
      3'd6:    r = {1'b0, i};
      default: r = {1'b1, {DATA_W{1'b0}}};
    endcase
    return r;
  endfunction

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s = state_r;
    rr_s    = rr_r;
    id_s    = id_r;
    op_s    = op_r;
    lu_a_s  = po_lu_a;
    lu_b_s  = po_lu_b;
    res_s   = po_res;
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    done0_s = 1'b0;
    done1_s = 1'b0;
    err_s   = 1'b0;
    busy_s  = 1'b0;
    grant_s = 1'b0;
    pick_s  = 1'b0;
    sel_s   = select_result(op_r, pi_lu_c, pi_lu_d, pi_lu_e, pi_lu_f,
                            pi_lu_g, pi_lu_h, pi_lu_i);
    case (state_r)
      IDLE: begin
        if (pi_req0 && pi_req1) begin
          grant_s = 1'b1;
          pick_s  = rr_r;
        end else if (pi_req0) begin
          grant_s = 1'b1;
          pick_s  = 1'b0;
        end else if (pi_req1) begin
          grant_s = 1'b1;
          pick_s  = 1'b1;
        end else begin
          grant_s = 1'b0;
          pick_s  = 1'b0;
        end
        if (grant_s) begin
          id_s    = pick_s;
          rr_s    = ~pick_s;
          op_s    = pick_s ? pi_op1 : pi_op0;
          lu_a_s  = pick_s ? pi_a1 : pi_a0;
          lu_b_s  = pick_s ? pi_b1 : pi_b0;
          gnt0_s  = ~pick_s;
          gnt1_s  = pick_s;
          busy_s  = 1'b1;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        // Logic unit has settled on the registered operands; capture now.
        res_s   = sel_s[DATA_W-1:0];
        err_s   = sel_s[DATA_W];
        done0_s = ~id_r;
        done1_s = id_r;
        busy_s  = 1'b1;
        state_s = RESULT;
      end
      RESULT: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, arbitration bookkeeping and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r  <= IDLE;
      rr_r     <= 1'b0;
      id_r     <= 1'b0;
      op_r     <= 3'd0;
      po_lu_a  <= {DATA_W{1'b0}};
      po_lu_b  <= {DATA_W{1'b0}};
      po_res   <= {DATA_W{1'b0}};
      po_gnt0  <= 1'b0;
      po_gnt1  <= 1'b0;
      po_done0 <= 1'b0;
      po_done1 <= 1'b0;
      po_err   <= 1'b0;
      po_busy  <= 1'b0;
    end else begin
      state_r  <= state_s;
      rr_r     <= rr_s;
      id_r     <= id_s;
      op_r     <= op_s;
      po_lu_a  <= lu_a_s;
      po_lu_b  <= lu_b_s;
      po_res   <= res_s;
      po_gnt0  <= gnt0_s;
      po_gnt1  <= gnt1_s;
      po_done0 <= done0_s;
      po_done1 <= done1_s;
      po_err   <= err_s;
      po_busy  <= busy_s;
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter with a behavioural model
// of the shared bitwise logic unit.
module tb_logic_op_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic [7:0] lu_c, lu_d, lu_e, lu_f, lu_g, lu_h, lu_i;
  logic [7:0] lu_a, lu_b, res;
  logic       gnt0, gnt1, done0, done1, err, busy;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic_op_arbiter #(.DATA_W(8)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .pi_req0(req0), .pi_op0(op0), .pi_a0(a0), .pi_b0(b0),
    .pi_req1(req1), .pi_op1(op1), .pi_a1(a1), .pi_b1(b1),
    .pi_lu_c(lu_c), .pi_lu_d(lu_d), .pi_lu_e(lu_e), .pi_lu_f(lu_f),
    .pi_lu_g(lu_g), .pi_lu_h(lu_h), .pi_lu_i(lu_i),
    .po_lu_a(lu_a), .po_lu_b(lu_b),
    .po_gnt0(gnt0), .po_gnt1(gnt1), .po_done0(done0), .po_done1(done1),
    .po_res(res), .po_err(err), .po_busy(busy)
  );

  // Shared logic unit model
  assign lu_c = lu_a & lu_b;
  assign lu_d = lu_a | lu_b;
  assign lu_e = ~(lu_a & lu_b);
  assign lu_f = ~(lu_a | lu_b);
  assign lu_g = lu_a ^ lu_b;
  assign lu_h = ~(lu_a ^ lu_b);
  assign lu_i = ~lu_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {26'd0, gnt0, gnt1, done0, done1, err, busy}, 32'd0);
  endtask

  // One complete transaction from a single requester, checked at every stage.
  task automatic run_op(input logic id, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res, input logic exp_err);
    if (id) begin
      req1 = 1'b1; op1 = op; a1 = a; b1 = b;
    end else begin
      req0 = 1'b1; op0 = op; a0 = a; b0 = b;
    end
    tick();
    check_eq("op_gnt", {30'd0, gnt0, gnt1}, {30'd0, ~id, id});
    check_eq("op_lu_a", {24'd0, lu_a}, {24'd0, a});
    check_eq("op_lu_b", {24'd0, lu_b}, {24'd0, b});
    check_eq("op_busy_load", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check_eq("op_done", {30'd0, done0, done1}, {30'd0, ~id, id});
    check_eq("op_res", {24'd0, res}, {24'd0, exp_res});
    check_eq("op_err", {31'd0, err}, {31'd0, exp_err});
    check_eq("op_gnt_low", {30'd0, gnt0, gnt1}, 32'd0);
    tick();
    check_quiet("op_idle");
    check_eq("op_res_hold", {24'd0, res}, {24'd0, exp_res});
  endtask

  logic [7:0] exp_tab [8];

  initial begin
    exp_tab = '{8'h80, 8'hDF, 8'h7F, 8'h20, 8'h5F, 8'hA0, 8'h3A, 8'h00};
    rst_n = 1'b0;
    req0 = 1'b1; op0 = 3'd0; a0 = 8'hF0; b0 = 8'h3C;
    req1 = 1'b0; op1 = 3'd0; a1 = 8'h00; b1 = 8'h00;

    // Reset held with a pending request
    for (int k = 0; k < 3; k++) begin
      tick();
      check_quiet("rst_ctl");
      check_eq("rst_data", {8'd0, lu_a, lu_b, res}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check_eq("single_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    check_eq("single_busy", {31'd0, busy}, 32'd1);
    check_eq("single_lu", {16'd0, lu_a, lu_b}, {16'd0, 8'hF0, 8'h3C});
    req0 = 1'b0;
    tick();
    check_eq("single_done", {30'd0, done0, done1}, 32'd2);
    check_eq("single_res", {24'd0, res}, 32'h30);
    check_eq("single_err", {31'd0, err}, 32'd0);
    tick();
    check_quiet("single_idle");
    check_eq("single_hold", {8'd0, lu_a, lu_b, res}, {8'd0, 8'hF0, 8'h3C, 8'h30});

    // Contention straight after reset
    rst_n = 1'b0;
    tick();
    req0 = 1'b1; op0 = 3'd4; a0 = 8'hAA; b0 = 8'h55;
    req1 = 1'b1; op1 = 3'd3; a1 = 8'h0F; b1 = 8'hF0;
    rst_n = 1'b1;
    tick();
    check_eq("cont_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
    req0 = 1'b0;
    tick();
    check_eq("cont_done0", {30'd0, done0, done1}, 32'd2);
    check_eq("cont_res0", {24'd0, res}, 32'hFF);
    tick();
    check_quiet("cont_gap");
    tick();
    check_eq("cont_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
    check_eq("cont_lu1", {16'd0, lu_a, lu_b}, {16'd0, 8'h0F, 8'hF0});
    req1 = 1'b0;
    tick();
    check_eq("cont_done1", {30'd0, done0, done1}, 32'd1);
    check_eq("cont_res1", {24'd0, res}, 32'h00);
    tick();

    // Fairness: both requesters keep coming back
    req0 = 1'b1; op0 = 3'd1; a0 = 8'hA0; b0 = 8'h0B;
    req1 = 1'b1; op1 = 3'd2; a1 = 8'hFF; b1 = 8'h0F;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) begin
        check_eq("fair_gnt", {30'd0, gnt0, gnt1}, 32'd2);
        req0 = 1'b0;
      end else begin
        check_eq("fair_gnt", {30'd0, gnt0, gnt1}, 32'd1);
        req1 = 1'b0;
      end
      tick();
      if (k % 2 == 0) begin
        check_eq("fair_res", {24'd0, res}, 32'hAB);
        req0 = 1'b1;
      end else begin
        check_eq("fair_res", {24'd0, res}, 32'hF0);
        req1 = 1'b1;
      end
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Every opcode on fixed operands
    for (int k = 0; k < 8; k++) begin
      run_op(1'b0, k[2:0], 8'hC5, 8'h9A, exp_tab[k], (k == 7));
    end

    // Illegal opcode then a legal one
    run_op(1'b1, 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1);
    run_op(1'b1, 3'd6, 8'h5A, 8'h00, 8'hA5, 1'b0);

    // Reset during LOAD with the pointer favouring requester 1
    run_op(1'b0, 3'd0, 8'h0F, 8'h0F, 8'h0F, 1'b0);
    req0 = 1'b1; op0 = 3'd1; a0 = 8'h33; b0 = 8'h44;
    tick();
    check_eq("mid_load_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    rst_n = 1'b0;
    req1 = 1'b1; op1 = 3'd0; a1 = 8'h11; b1 = 8'h22;
    tick();
    check_quiet("mid_rst_ctl");
    check_eq("mid_rst_data", {8'd0, lu_a, lu_b, res}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("mid_ptr_gnt", {30'd0, gnt0, gnt1}, 32'd2);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check_eq("mid_done", {30'd0, done0, done1}, 32'd2);
    check_eq("mid_res", {24'd0, res}, 32'h77);
    tick();
    check_quiet("mid_idle");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
